// File: rtl/regfile_pkg.sv
// Register-file constants shared by the core and the dump reader: geometry,
// architected reset values of gp/sp, and the dump reader state encoding.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;

  localparam int REG_GP = 28;
  localparam int REG_SP = 29;

  localparam logic [REG_DATA_W-1:0] GP_RESET = 32'h1000_8000;
  localparam logic [REG_DATA_W-1:0] SP_RESET = 32'h7FFF_EFFC;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HALT_WAIT = 2'd1,
    READ      = 2'd2,
    HOLD      = 2'd3
  } dump_state_e;

  // Contents a freshly reset register file holds at a given index.
  function automatic logic [REG_DATA_W-1:0] reg_reset_value(input int idx);
    if (idx == REG_GP) return GP_RESET;
    if (idx == REG_SP) return SP_RESET;
    return '0;
  endfunction

endpackage

// File: rtl/regfile_dump_reader.sv
// Debug reader: freezes core register writes, walks the register file through
// one read port and streams each value out tagged with its index, with a running XOR checksum.
module regfile_dump_reader
  import regfile_pkg::*;
#(
  parameter int NUM_REGS  = 32,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int FIRST_REG = 0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              Start,
  input  logic              Abort,
  output logic              Halt_req,
  input  logic              Halt_ack,
  output logic [ADDR_W-1:0] Read_register,
  input  logic [DATA_W-1:0] Read_data,
  output logic              Out_valid,
  input  logic              Out_ready,
  output logic [ADDR_W-1:0] Out_index,
  output logic [DATA_W-1:0] Out_data,
  output logic              Busy,
  output logic              Done,
  output logic [DATA_W-1:0] Checksum
);

  if (FIRST_REG >= NUM_REGS || NUM_REGS > (1 << ADDR_W)) begin : g_bad_params
    $error("regfile_dump_reader: need FIRST_REG < NUM_REGS <= 2**ADDR_W");
  end

  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              halt_req_q, halt_req_d;
  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] out_index_q, out_index_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] checksum_q, checksum_d;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    halt_req_d  = halt_req_q;
    out_valid_d = out_valid_q;
    out_index_d = out_index_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;
    checksum_d  = checksum_q;

    // Abort outranks everything; in IDLE it only suppresses a coincident Start.
    if (Abort) begin
      if (state_q != IDLE) begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        halt_req_d  = 1'b0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (Start) begin
            state_d    = HALT_WAIT;
            idx_d      = FIRST_IDX;
            checksum_d = '0;
            halt_req_d = 1'b1;
          end
        end
        HALT_WAIT: begin
          if (Halt_ack) state_d = READ;
        end
        READ: begin
          out_data_d  = Read_data;
          out_index_d = idx_q;
          out_valid_d = 1'b1;
          checksum_d  = checksum_q ^ Read_data;
          state_d     = HOLD;
        end
        HOLD: begin
          if (Out_ready) begin
            out_valid_d = 1'b0;
            if (idx_q == LAST_IDX) begin
              halt_req_d = 1'b0;
              done_d     = 1'b1;
              state_d    = IDLE;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = Halt_ack ? READ : HALT_WAIT;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      halt_req_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
      checksum_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      halt_req_q  <= halt_req_d;
      out_valid_q <= out_valid_d;
      out_index_q <= out_index_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
      checksum_q  <= checksum_d;
    end
  end

  // The index register doubles as the registered read-port address.
  assign Read_register = idx_q;
  assign Halt_req      = halt_req_q;
  assign Out_valid     = out_valid_q;
  assign Out_index     = out_index_q;
  assign Out_data      = out_data_q;
  assign Busy          = (state_q != IDLE);
  assign Done          = done_q;
  assign Checksum      = checksum_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader: a register-file array answers the
// read port, and each dump's expected word stream and checksum come from that array.
module tb_regfile_dump_reader;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          Start = 1'b0;
  logic          Abort = 1'b0;
  logic          Halt_req;
  logic          Halt_ack = 1'b1;
  logic [AW-1:0] Read_register;
  logic [DW-1:0] Read_data;
  logic          Out_valid;
  logic          Out_ready = 1'b1;
  logic [AW-1:0] Out_index;
  logic [DW-1:0] Out_data;
  logic          Busy;
  logic          Done;
  logic [DW-1:0] Checksum;

  logic [DW-1:0] regs [NREG];

  typedef struct packed {
    logic [AW-1:0] idx;
    logic [DW-1:0] data;
  } word_t;

  word_t         exp_q[$];
  logic [DW-1:0] cs_q[$];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int words_seen = 0;

  regfile_dump_reader #(.NUM_REGS(NREG), .ADDR_W(AW), .DATA_W(DW), .FIRST_REG(0)) dut (
    .CLK(CLK), .RESET(RESET), .Start(Start), .Abort(Abort),
    .Halt_req(Halt_req), .Halt_ack(Halt_ack),
    .Read_register(Read_register), .Read_data(Read_data),
    .Out_valid(Out_valid), .Out_ready(Out_ready),
    .Out_index(Out_index), .Out_data(Out_data),
    .Busy(Busy), .Done(Done), .Checksum(Checksum)
  );

  always #5 CLK = ~CLK;

  assign Read_data = regs[Read_register];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_idx;
  logic [DW-1:0] prev_data;
  logic          prev_halt = 1'b0;

  always @(negedge CLK) begin
    if (RESET) begin
      prev_stall = 1'b0;
      prev_halt  = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", Out_valid, 1'b1);
        check("stall_index_held", Out_index, prev_idx);
        check("stall_data_held", Out_data, prev_data);
      end
      prev_stall = Out_valid && !Out_ready && !Abort;
      prev_idx   = Out_index;
      prev_data  = Out_data;

      if (Out_valid && Out_ready && !Abort) begin
        words_seen++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word: got index %0d data %0h, none expected", Out_index, Out_data);
        end else begin
          word_t w;
          w = exp_q.pop_front();
          check("word_index", Out_index, w.idx);
          check("word_data", Out_data, w.data);
        end
      end

      if (Done) begin
        done_cnt++;
        check("halt_req_low_at_done", Halt_req, 1'b0);
        check("halt_req_high_before_done", prev_halt, 1'b1);
        check("words_left_at_done", exp_q.size(), 0);
        if (cs_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got Done=1, expected no completion");
        end else begin
          check("checksum_at_done", Checksum, cs_q.pop_front());
        end
      end
      prev_halt = Halt_req;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic flush_model();
    exp_q.delete();
    cs_q.delete();
  endtask

  task automatic reset_regfile();
    for (int i = 0; i < NREG; i++) regs[i] = regfile_pkg::reg_reset_value(i);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_halt_req"}, Halt_req, 1'b0);
    check({tag, "_read_register"}, Read_register, 0);
    check({tag, "_out_valid"}, Out_valid, 1'b0);
    check({tag, "_out_index"}, Out_index, 0);
    check({tag, "_out_data"}, Out_data, 0);
    check({tag, "_busy"}, Busy, 1'b0);
    check({tag, "_done"}, Done, 1'b0);
    check({tag, "_checksum"}, Checksum, 0);
  endtask

  // Expected stream is simply every register in index order; checksum is their XOR.
  task automatic start_dump();
    logic [DW-1:0] cs;
    word_t w;
    cs = '0;
    for (int i = 0; i < NREG; i++) begin
      w.idx  = AW'(i);
      w.data = regs[i];
      exp_q.push_back(w);
      cs ^= regs[i];
    end
    cs_q.push_back(cs);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check("start_busy", Busy, 1'b1);
    check("start_halt_req", Halt_req, 1'b1);
    check("start_checksum_cleared", Checksum, 0);
    check("start_read_register", Read_register, 0);
  endtask

  task automatic wait_done(input int budget);
    int d0;
    d0 = done_cnt;
    for (int c = 0; c < budget; c++) begin
      if (done_cnt != d0) return;
      tick();
    end
    checks++; errors++;
    $display("FAIL done_timeout: got no Done within %0d cycles, expected one", budget);
  endtask

  task automatic wait_word(input int idx, input int budget);
    for (int c = 0; c < budget; c++) begin
      if (Out_valid && Out_index == AW'(idx)) return;
      tick();
    end
    checks++; errors++;
    $display("FAIL word_timeout: got no word %0d within %0d cycles, expected it", idx, budget);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int d0;
    logic [DW-1:0] partial;
    logic pat [4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

    reset_regfile();
    RESET = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");
    RESET = 1'b0;
    tick();

    // 1: reset register file, full-speed dump
    words_seen = 0;
    d0 = done_cnt;
    start_dump();
    wait_done(200);
    check("t1_done_count", done_cnt - d0, 1);
    check("t1_words", words_seen, 32);
    check("t1_checksum_const", Checksum, 32'h6FFF_6FFC);
    repeat (3) tick();
    check("t1_checksum_held", Checksum, 32'h6FFF_6FFC);
    check("t1_single_done", done_cnt - d0, 1);

    // 2: stalled consumer with r8 preloaded
    regs[8] = 32'hDEAD_BEEF;
    start_dump();
    for (int c = 0; c < 400 && cs_q.size() != 0; c++) begin
      Out_ready = pat[c % 4];
      tick();
    end
    Out_ready = 1'b1;
    check("t2_completed", cs_q.size(), 0);

    // 3: Halt_ack withheld after Start
    Halt_ack = 1'b0;
    start_dump();
    for (int c = 0; c < 10; c++) begin
      check("t3_halt_req", Halt_req, 1'b1);
      check("t3_no_valid", Out_valid, 1'b0);
      check("t3_read_reg", Read_register, 0);
      tick();
    end
    Halt_ack = 1'b1;
    tick();
    check("t3_valid_after_1", Out_valid, 1'b0);
    tick();
    check("t3_valid_after_2", Out_valid, 1'b1);
    check("t3_first_index", Out_index, 0);
    wait_done(200);

    // 4: Halt_ack dropped while word 5 is held
    start_dump();
    wait_word(5, 100);
    Out_ready = 1'b0;
    Halt_ack  = 1'b0;
    repeat (2) tick();
    Out_ready = 1'b1;
    tick();
    check("t4_valid_dropped", Out_valid, 1'b0);
    check("t4_next_read_reg", Read_register, 6);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("t4_waiting_busy", Busy, 1'b1);
      check("t4_waiting_no_valid", Out_valid, 1'b0);
    end
    Halt_ack = 1'b1;
    wait_done(200);

    // 5: Abort while word 12 is held
    for (int i = 0; i < NREG; i++) regs[i] = $urandom;
    start_dump();
    wait_word(12, 100);
    Out_ready = 1'b0;
    Abort = 1'b1;
    partial = '0;
    for (int i = 0; i <= 12; i++) partial ^= regs[i];
    d0 = done_cnt;
    tick();
    Abort = 1'b0;
    Out_ready = 1'b1;
    check("t5_valid_low", Out_valid, 1'b0);
    check("t5_halt_low", Halt_req, 1'b0);
    check("t5_idle", Busy, 1'b0);
    check("t5_partial_checksum", Checksum, partial);
    flush_model();
    repeat (5) tick();
    check("t5_no_done", done_cnt - d0, 0);
    start_dump();
    wait_done(200);

    // 6: Start while busy is ignored; RESET mid-dump
    start_dump();
    wait_word(3, 100);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    wait_word(20, 100);
    RESET = 1'b1;
    tick();
    check_reset_outputs("t6_reset");
    RESET = 1'b0;
    flush_model();
    tick();

    // Randomized dumps: random contents, random back-pressure and halt drops
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NREG; i++) regs[i] = $urandom;
      d0 = done_cnt;
      start_dump();
      for (int c = 0; c < 2000 && done_cnt == d0; c++) begin
        Out_ready = ($urandom_range(0, 3) != 0);
        Halt_ack  = ($urandom_range(0, 7) != 0);
        tick();
      end
      Out_ready = 1'b1;
      Halt_ack  = 1'b1;
      check("rand_done", done_cnt - d0, 1);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no end of test, expected completion");
    $fatal(1, "timeout");
  end

endmodule
